// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Request and instruction-memory write bus of the instruction encoder.
//   req_valid/req_ready   : request handshake
//   req_op/rd/rs1/rs2/imm : symbolic instruction fields
//   mem_we/addr/wdata     : one-cycle instruction-memory write
// master = request source / memory side, slave = instr_encoder.
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
   parameter int ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [5:0]        req_op;
   logic [4:0]        req_rd;
   logic [4:0]        req_rs1;
   logic [4:0]        req_rs2;
   logic [31:0]       req_imm;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
      input  req_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
      output req_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Packs symbolic instruction requests into RV32I words and writes them
// sequentially into instruction memory (program loader / test generator).
//
// Ports:
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset
//   start       : rewind to BASE_ADDR, clear count/full/err_sticky, abort request
//   bus         : instr_encoder_if.slave (request handshake + memory write)
//   count       : words written since reset/start (ADDR_W+1 bits)
//   full        : count == 2**ADDR_W
//   err         : one-cycle pulse, request rejected
//   err_sticky  : set by err, cleared by start/reset
//   char_out    : 5-char ASCII mnemonic (only with ENC_MNEMONIC_EN defined)
//
// Optional feature macro: ENC_MNEMONIC_EN
// -----------------------------------------------------------------------------
module instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   instr_encoder_if.slave  bus,
   output logic [ADDR_W:0] count,
   output logic            full,
   output logic            err,
   output logic            err_sticky
`ifdef ENC_MNEMONIC_EN
   ,
   output logic [39:0]     char_out
`endif
);

   typedef enum logic [1:0] {IDLE, PACK, WRITE} state_t;

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};

   state_t             state_q;
   logic [5:0]         op_q;
   logic [4:0]         rd_q, rs1_q, rs2_q;
   logic signed [31:0] imm_q;
   logic [ADDR_W-1:0]  addr_q;      // address of the next write
   logic [ADDR_W-1:0]  mem_addr_q;
   logic               mem_we_q;
   logic [31:0]        mem_wdata_q;
   logic [ADDR_W:0]    count_q;
   logic               full_q, err_q, err_sticky_q;
   logic               accept;
   logic [31:0]        word_d;
   logic               legal_d;

   function automatic logic [31:0] encode(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic signed [31:0] imm);
      logic [2:0] f3;
      logic [6:0] f7;
      f7 = (op == 6'd2 || op == 6'd8 || op == 6'd19) ? 7'h20 : 7'h00;
      case (op)
         6'd3, 6'd17, 6'd21, 6'd26, 6'd29:        f3 = 3'd1;
         6'd4, 6'd12, 6'd22, 6'd27:               f3 = 3'd2;
         6'd5, 6'd13:                             f3 = 3'd3;
         6'd6, 6'd14, 6'd23, 6'd30:               f3 = 3'd4;
         6'd7, 6'd8, 6'd18, 6'd19, 6'd24, 6'd31:  f3 = 3'd5;
         6'd9, 6'd15, 6'd32:                      f3 = 3'd6;
         6'd10, 6'd16, 6'd33:                     f3 = 3'd7;
         default:                                 f3 = 3'd0;
      endcase
      if (op == 6'd0 || op > 6'd37) encode = 32'h0000_0000;
      else if (op <= 6'd10) encode = {f7, rs2, rs1, f3, rd, 7'h33};
      else if (op <= 6'd16) encode = {imm[11:0], rs1, f3, rd, 7'h13};
      else if (op <= 6'd19) encode = {f7, imm[4:0], rs1, f3, rd, 7'h13};
      else if (op <= 6'd24) encode = {imm[11:0], rs1, f3, rd, 7'h03};
      else if (op <= 6'd27) encode = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
      else if (op <= 6'd33) encode = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
      else if (op == 6'd34) encode = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
      else if (op == 6'd35) encode = {imm[11:0], rs1, f3, rd, 7'h67};
      else if (op == 6'd36) encode = {imm[31:12], rd, 7'h37};
      else                  encode = {imm[31:12], rd, 7'h17};
   endfunction

   // Only the immediate is range-checked; register fields always fit.
   function automatic logic is_legal(input logic [5:0] op, input logic signed [31:0] imm);
      if (op <= 6'd10)
         is_legal = 1'b1;
      else if (op <= 6'd16 || (op >= 6'd20 && op <= 6'd27) || op == 6'd35)
         is_legal = (imm >= -32'sd2048) && (imm <= 32'sd2047);
      else if (op <= 6'd19)
         is_legal = (imm >= 32'sd0) && (imm <= 32'sd31);
      else if (op <= 6'd33)
         is_legal = (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
      else if (op == 6'd34)
         is_legal = (imm >= -32'sd1048576) && (imm <= 32'sd1048574) && !imm[0];
      else if (op <= 6'd37)
         is_legal = (imm[11:0] == 12'h000);
      else
         is_legal = 1'b0;
   endfunction

`ifdef ENC_MNEMONIC_EN
   function automatic logic [39:0] mnemonic(input logic [5:0] op);
      case (op)
         6'd0:  mnemonic = "NOP  ";  6'd1:  mnemonic = "ADD  ";  6'd2:  mnemonic = "SUB  ";
         6'd3:  mnemonic = "SLL  ";  6'd4:  mnemonic = "SLT  ";  6'd5:  mnemonic = "SLTU ";
         6'd6:  mnemonic = "XOR  ";  6'd7:  mnemonic = "SRL  ";  6'd8:  mnemonic = "SRA  ";
         6'd9:  mnemonic = "OR   ";  6'd10: mnemonic = "AND  ";  6'd11: mnemonic = "ADDI ";
         6'd12: mnemonic = "SLTI ";  6'd13: mnemonic = "SLTIU";  6'd14: mnemonic = "XORI ";
         6'd15: mnemonic = "ORI  ";  6'd16: mnemonic = "ANDI ";  6'd17: mnemonic = "SLLI ";
         6'd18: mnemonic = "SRLI ";  6'd19: mnemonic = "SRAI ";  6'd20: mnemonic = "LB   ";
         6'd21: mnemonic = "LH   ";  6'd22: mnemonic = "LW   ";  6'd23: mnemonic = "LBU  ";
         6'd24: mnemonic = "LHU  ";  6'd25: mnemonic = "SB   ";  6'd26: mnemonic = "SH   ";
         6'd27: mnemonic = "SW   ";  6'd28: mnemonic = "BEQ  ";  6'd29: mnemonic = "BNE  ";
         6'd30: mnemonic = "BLT  ";  6'd31: mnemonic = "BGE  ";  6'd32: mnemonic = "BLTU ";
         6'd33: mnemonic = "BGEU ";  6'd34: mnemonic = "JAL  ";  6'd35: mnemonic = "JALR ";
         6'd36: mnemonic = "LUI  ";  6'd37: mnemonic = "AUIPC";
         default: mnemonic = "XXXXX";
      endcase
   endfunction
`endif

   // start masks ready combinationally so a simultaneous request is never taken.
   assign bus.req_ready = (state_q == IDLE) && !full_q && !start;
   assign accept        = bus.req_valid && bus.req_ready;
   assign word_d        = encode(op_q, rd_q, rs1_q, rs2_q, imm_q);
   assign legal_d       = is_legal(op_q, imm_q);

   // accept -> fields captured for PACK
   always_ff @(posedge clock) begin
      if (accept) begin
         op_q  <= bus.req_op;
         rd_q  <= bus.req_rd;
         rs1_q <= bus.req_rs1;
         rs2_q <= bus.req_rs2;
         imm_q <= bus.req_imm;
      end
   end

   // PACK -> registered write strobe / error pulse
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= BASE;
         mem_wdata_q  <= 32'h0000_0000;
         addr_q       <= BASE;
         count_q      <= '0;
         full_q       <= 1'b0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
`ifdef ENC_MNEMONIC_EN
         char_out     <= "XXXXX";
`endif
      end else if (start) begin
         state_q      <= IDLE;
         mem_we_q     <= 1'b0;
         addr_q       <= BASE;
         count_q      <= '0;
         full_q       <= 1'b0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         err_q    <= 1'b0;
         case (state_q)
            IDLE:  if (accept) state_q <= PACK;
            PACK: begin
               if (legal_d) begin
                  state_q     <= WRITE;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= addr_q;
                  mem_wdata_q <= word_d;
                  addr_q      <= addr_q + ADDR_W'(1);   // wraps naturally at 2**ADDR_W
                  count_q     <= count_q + (ADDR_W+1)'(1);
                  full_q      <= (count_q + (ADDR_W+1)'(1)) == CAP;
`ifdef ENC_MNEMONIC_EN
                  char_out    <= mnemonic(op_q);
`endif
               end else begin
                  state_q      <= IDLE;
                  err_q        <= 1'b1;
                  err_sticky_q <= 1'b1;
`ifdef ENC_MNEMONIC_EN
                  char_out     <= "XXXXX";
`endif
               end
            end
            WRITE:   state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign count         = count_q;
   assign full          = full_q;
   assign err           = err_q;
   assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n, start, req_valid;
   logic [5:0]  req_op;
   logic [4:0]  req_rd, req_rs1, req_rs2;
   logic [31:0] req_imm;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // Two encoders share the request stream: a default-size one and a 4-word
   // one based at address 2 so that full and address wrap are reachable.
   instr_encoder_if #(.ADDR_W(8)) bus_b ();
   instr_encoder_if #(.ADDR_W(2)) bus_s ();

   assign bus_b.req_valid = req_valid;  assign bus_s.req_valid = req_valid;
   assign bus_b.req_op    = req_op;     assign bus_s.req_op    = req_op;
   assign bus_b.req_rd    = req_rd;     assign bus_s.req_rd    = req_rd;
   assign bus_b.req_rs1   = req_rs1;    assign bus_s.req_rs1   = req_rs1;
   assign bus_b.req_rs2   = req_rs2;    assign bus_s.req_rs2   = req_rs2;
   assign bus_b.req_imm   = req_imm;    assign bus_s.req_imm   = req_imm;

   logic [8:0] count_b;
   logic [2:0] count_s;
   logic       full_b, err_b, sticky_b, full_s, err_s, sticky_s;

   instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_big (
      .clock(clk), .reset(rst_n), .start(start), .bus(bus_b),
      .count(count_b), .full(full_b), .err(err_b), .err_sticky(sticky_b));

   instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) u_small (
      .clock(clk), .reset(rst_n), .start(start), .bus(bus_s),
      .count(count_s), .full(full_s), .err(err_s), .err_sticky(sticky_s));

   // ---------------- reference model ----------------
   int m_addr_b, m_cnt_b, m_addr_s, m_cnt_s;
   bit m_full_s;

   int f3_tab [38] = '{0, 0,0,1,2,3,4,5,5,6,7, 0,2,3,4,6,7,1,5,5, 0,1,2,4,5, 0,1,2,
                       0,1,4,5,6,7, 0,0,0,0};
   int imm_edges [18] = '{-2048, 2047, 2048, -2049, 0, 31, 32, -1, 4094, 4095, -4096,
                          -4098, 1048574, 1048576, -1048576, 4096, 'h12345000, 'h7FFFF000};

   function automatic bit ref_legal(input int op, input int imm);
      if (op <= 10) return 1'b1;
      if ((op >= 11 && op <= 16) || (op >= 20 && op <= 27) || op == 35)
         return imm >= -2048 && imm <= 2047;
      if (op >= 17 && op <= 19) return imm >= 0 && imm <= 31;
      if (op >= 28 && op <= 33) return imm >= -4096 && imm <= 4094 && (imm % 2 == 0);
      if (op == 34) return imm >= -1048576 && imm <= 1048574 && (imm % 2 == 0);
      if (op == 36 || op == 37) return (imm % 4096) == 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_word(input int op, input int rd, input int rs1,
                                            input int rs2, input int imm);
      int f3, f7, regs;
      if (op == 0 || op > 37) return 32'h0;
      f3   = f3_tab[op];
      f7   = (op == 2 || op == 8 || op == 19) ? 'h20 : 0;
      regs = (rs1 << 15) | (f3 << 12);
      if (op <= 10) return (f7 << 25) | (rs2 << 20) | regs | (rd << 7) | 'h33;
      if (op <= 16) return ((imm & 'hFFF) << 20) | regs | (rd << 7) | 'h13;
      if (op <= 19) return (f7 << 25) | ((imm & 31) << 20) | regs | (rd << 7) | 'h13;
      if (op <= 24) return ((imm & 'hFFF) << 20) | regs | (rd << 7) | 'h03;
      if (op <= 27) return (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | regs | ((imm & 31) << 7) | 'h23;
      if (op <= 33) return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20) | regs
                           | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
      if (op == 34) return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21)
                           | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
      if (op == 35) return ((imm & 'hFFF) << 20) | regs | (rd << 7) | 'h67;
      return (imm & 'hFFFFF000) | (rd << 7) | (op == 36 ? 'h37 : 'h17);
   endfunction

   task automatic model_rewind();
      m_addr_b = 0; m_cnt_b = 0; m_addr_s = 2; m_cnt_s = 0; m_full_s = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus_b.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
   endtask

   // One full transaction from the negedge before acceptance to cycle N+3.
   task automatic send(input int op, input int rd, input int rs1, input int rs2,
                       input int imm, output logic [31:0] got);
      bit          legal, s_acc;
      logic [31:0] exp;
      legal = ref_legal(op, imm);
      exp   = ref_word(op, rd, rs1, rs2, imm);
      s_acc = !m_full_s;
      wait_idle();
      checks++;
      if (bus_b.req_ready !== 1'b1) begin errors++; $display("FAIL ready_wait op=%0d got=%b exp=1", op, bus_b.req_ready); end
      checks++;
      if (bus_s.req_ready !== s_acc) begin errors++; $display("FAIL ready_small got=%b exp=%b", bus_s.req_ready, s_acc); end
      req_valid = 1'b1; req_op = 6'(op); req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2); req_imm = imm;
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({bus_b.req_ready, bus_b.mem_we, err_b} !== 3'b000) begin
         errors++; $display("FAIL pack_cycle ready/we/err got=%b exp=000", {bus_b.req_ready, bus_b.mem_we, err_b});
      end
      @(negedge clk);
      if (legal) begin
         checks++;
         if ({bus_b.mem_we, err_b} !== 2'b10) begin errors++; $display("FAIL write_strobe op=%0d we/err got=%b exp=10", op, {bus_b.mem_we, err_b}); end
         checks++;
         if (bus_b.mem_addr !== 8'(m_addr_b)) begin errors++; $display("FAIL write_addr got=%0d exp=%0d", bus_b.mem_addr, m_addr_b); end
         checks++;
         if (bus_b.mem_wdata !== exp) begin errors++; $display("FAIL wdata op=%0d imm=%0d got=%h exp=%h", op, imm, bus_b.mem_wdata, exp); end
         m_addr_b = (m_addr_b + 1) % 256;
         m_cnt_b++;
      end else begin
         checks++;
         if ({bus_b.mem_we, err_b, sticky_b} !== 3'b011) begin
            errors++; $display("FAIL reject op=%0d imm=%0d we/err/sticky got=%b exp=011", op, imm, {bus_b.mem_we, err_b, sticky_b});
         end
      end
      checks++;
      if (count_b !== 9'(m_cnt_b)) begin errors++; $display("FAIL count got=%0d exp=%0d", count_b, m_cnt_b); end
      if (s_acc && legal) begin
         checks++;
         if ({bus_s.mem_we, bus_s.mem_addr, bus_s.mem_wdata} !== {1'b1, 2'(m_addr_s), exp}) begin
            errors++; $display("FAIL small_write we=%b addr=%0d data=%h exp addr=%0d data=%h", bus_s.mem_we, bus_s.mem_addr, bus_s.mem_wdata, m_addr_s, exp);
         end
         m_addr_s = (m_addr_s + 1) % 4;
         m_cnt_s++;
         m_full_s = (m_cnt_s == 4);
         checks++;
         if ({count_s, full_s} !== {3'(m_cnt_s), m_full_s}) begin
            errors++; $display("FAIL small_count count/full got=%0d/%b exp=%0d/%b", count_s, full_s, m_cnt_s, m_full_s);
         end
      end else begin
         checks++;
         if ({bus_s.mem_we, err_s} !== {1'b0, s_acc}) begin
            errors++; $display("FAIL small_nowrite we/err got=%b exp=%b", {bus_s.mem_we, err_s}, {1'b0, s_acc});
         end
      end
      got = bus_b.mem_wdata;
      @(negedge clk);
      checks++;
      if ({bus_b.req_ready, bus_b.mem_we, err_b} !== 3'b100) begin
         errors++; $display("FAIL recover ready/we/err got=%b exp=100", {bus_b.req_ready, bus_b.mem_we, err_b});
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      #1;
      checks++;
      if ({bus_b.req_ready, bus_s.req_ready} !== 2'b00) begin errors++; $display("FAIL start_blocks_ready got=%b exp=00", {bus_b.req_ready, bus_s.req_ready}); end
      @(negedge clk);
      start = 1'b0;
      model_rewind();
      checks++;
      if ({count_b, full_b, sticky_b, count_s, full_s, sticky_s} !== 16'h0) begin
         errors++; $display("FAIL start_clear cnt_b=%0d full_b=%b st_b=%b cnt_s=%0d full_s=%b st_s=%b exp all 0",
                            count_b, full_b, sticky_b, count_s, full_s, sticky_s);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b1; start = 1'b0; req_valid = 1'b0;
      req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus_b.mem_we, bus_b.mem_addr, bus_b.mem_wdata, count_b, full_b, err_b, sticky_b} !== 52'h0) begin
         errors++; $display("FAIL reset_big we=%b addr=%0d data=%h cnt=%0d full=%b err=%b st=%b exp zeros",
                            bus_b.mem_we, bus_b.mem_addr, bus_b.mem_wdata, count_b, full_b, err_b, sticky_b);
      end
      checks++;
      if ({bus_s.mem_we, bus_s.mem_addr, count_s, full_s, err_s} !== {1'b0, 2'd2, 3'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset_small we=%b addr=%0d cnt=%0d exp addr=2", bus_s.mem_we, bus_s.mem_addr, count_s);
      end
      rst_n = 1'b1;
      model_rewind();
      @(negedge clk);
      checks++;
      if (bus_b.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus_b.req_ready); end
   endtask

   task automatic test_known_vectors();
      logic [31:0] w;
      send(11, 1, 0, 0, 5, w);
      checks++; if (w !== 32'h00500093) begin errors++; $display("FAIL vec_addi got=%h exp=00500093", w); end
      send(1, 3, 1, 2, 0, w);
      checks++; if (w !== 32'h002081B3) begin errors++; $display("FAIL vec_add got=%h exp=002081B3", w); end
      send(2, 3, 1, 2, 0, w);
      checks++; if (w !== 32'h402081B3) begin errors++; $display("FAIL vec_sub got=%h exp=402081B3", w); end
      send(28, 0, 1, 2, 8, w);
      checks++; if (w !== 32'h00208463) begin errors++; $display("FAIL vec_beq got=%h exp=00208463", w); end
      send(19, 1, 1, 0, 3, w);
      checks++; if (w !== 32'h4030D093) begin errors++; $display("FAIL vec_srai got=%h exp=4030D093", w); end
      send(36, 5, 0, 0, 'h12345000, w);
      checks++; if (w !== 32'h123452B7) begin errors++; $display("FAIL vec_lui got=%h exp=123452B7", w); end
      send(0, 7, 7, 7, 99, w);
      checks++; if (w !== 32'h00000000) begin errors++; $display("FAIL vec_nop got=%h exp=00000000", w); end
   endtask

   task automatic test_range_errors();
      logic [31:0] w;
      int          cnt0;
      cnt0 = m_cnt_b;
      send(11, 1, 0, 0, 2048, w);
      send(28, 0, 1, 2, 7, w);
      send(40, 1, 1, 1, 0, w);
      send(17, 1, 1, 0, 32, w);
      send(34, 1, 0, 0, 1048576, w);
      send(37, 1, 0, 0, 'h1001, w);
      checks++;
      if (count_b !== 9'(cnt0)) begin errors++; $display("FAIL err_count_held got=%0d exp=%0d", count_b, cnt0); end
      // boundary values that must be accepted; sticky stays set across them
      send(11, 2, 3, 0, -2048, w);
      send(11, 2, 3, 0, 2047, w);
      send(17, 2, 3, 0, 31, w);
      send(33, 0, 4, 5, -4096, w);
      send(34, 1, 0, 0, -1048576, w);
      send(37, 9, 0, 0, 'h7FFFF000, w);
      checks++;
      if (sticky_b !== 1'b1) begin errors++; $display("FAIL sticky_hold got=%b exp=1", sticky_b); end
      do_start();
   endtask

   task automatic test_start_priority();
      logic [31:0] w;
      send(1, 1, 2, 3, 0, w);
      wait_idle();
      start = 1'b1; req_valid = 1'b1; req_op = 6'd11; req_rd = 5'd4; req_imm = 32'd1;
      #1;
      checks++;
      if (bus_b.req_ready !== 1'b0) begin errors++; $display("FAIL prio_ready got=%b exp=0", bus_b.req_ready); end
      @(negedge clk);
      start = 1'b0; req_valid = 1'b0;
      model_rewind();
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({bus_b.mem_we, err_b, bus_b.req_ready} !== 3'b001) begin
            errors++; $display("FAIL prio_no_accept we/err/ready got=%b exp=001", {bus_b.mem_we, err_b, bus_b.req_ready});
         end
      end
      send(11, 1, 0, 0, 5, w);
   endtask

   task automatic test_abort();
      logic [31:0] w;
      // start while the request sits in PACK
      wait_idle();
      req_valid = 1'b1; req_op = 6'd11; req_rd = 5'd1; req_rs1 = 5'd0; req_imm = 32'd5;
      @(negedge clk);
      req_valid = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_rewind();
      checks++;
      if ({bus_b.mem_we, err_b, count_b, bus_s.mem_we, err_s} !== 13'h0) begin
         errors++; $display("FAIL start_abort we=%b err=%b cnt=%0d exp 0/0/0", bus_b.mem_we, err_b, count_b);
      end
      send(1, 5, 6, 7, 0, w);
      send(1, 5, 6, 7, 0, w);
      // reset while the request sits in PACK
      wait_idle();
      req_valid = 1'b1; req_op = 6'd22; req_rd = 5'd2; req_rs1 = 5'd3; req_imm = 32'd16;
      @(negedge clk);
      req_valid = 1'b0; rst_n = 1'b0;
      #1;
      checks++;
      if ({bus_b.mem_we, count_b} !== 10'h0) begin errors++; $display("FAIL reset_abort we=%b cnt=%0d exp 0/0", bus_b.mem_we, count_b); end
      @(negedge clk);
      rst_n = 1'b1;
      model_rewind();
      @(negedge clk);
      checks++;
      if ({bus_b.mem_we, err_b, bus_b.req_ready} !== 3'b001) begin
         errors++; $display("FAIL reset_recover we/err/ready got=%b exp=001", {bus_b.mem_we, err_b, bus_b.req_ready});
      end
      send(22, 2, 3, 0, 16, w);
   endtask

   task automatic test_full_wrap();
      logic [31:0] w;
      do_start();
      repeat (4) send($urandom_range(1, 10), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 0, w);
      checks++;
      if ({full_s, bus_s.req_ready, count_s} !== {1'b1, 1'b0, 3'd4}) begin
         errors++; $display("FAIL small_full full/ready/cnt got=%b/%b/%0d exp=1/0/4", full_s, bus_s.req_ready, count_s);
      end
      send(11, 1, 1, 0, 1, w);          // small encoder holds off this one
      checks++;
      if ({full_s, count_s, full_b} !== {1'b1, 3'd4, 1'b0}) begin
         errors++; $display("FAIL full_held full_s=%b cnt_s=%0d full_b=%b exp=1/4/0", full_s, count_s, full_b);
      end
      do_start();
      repeat (5) send($urandom_range(11, 16), $urandom_range(0, 31), $urandom_range(0, 31), 0, $urandom_range(0, 2047), w);
   endtask

   task automatic test_random();
      logic [31:0] w;
      int          op, imm;
      do_start();
      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 45);
         case ($urandom_range(0, 3))
            0:       imm = int'($urandom_range(0, 63)) - 32;
            1:       imm = int'($urandom_range(0, 8191)) - 4096;
            2:       imm = int'($urandom);
            default: imm = imm_edges[$urandom_range(0, 17)];
         endcase
         send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm, w);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_known_vectors();
      test_range_errors();
      test_start_priority();
      test_abort();
      test_full_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
